// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : uart_pkg                                                     |
// | Purpose   : Shared UART definitions: FSM state encodings and the frame   |
// |             data width. Used by both the receive and transmit paths.     |
// | Contents  : DATA_W, uart_state_t                                         |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : uart_baud_tick                                               |
// | Purpose   : Divides the system clock down to the oversample tick. Counts |
// |             0..DIVISOR-1 and pulses tick on the wrap cycle.              |
// | Ports     : clock  - system clock                                        |
// |             reset  - asynchronous active-high reset                      |
// |             clear  - synchronous restart of the count (phase align)      |
// |             tick   - one-cycle pulse every DIVISOR clocks                |
// | Params    : DIVISOR - clocks per tick (>=1)                              |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module uart_baud_tick #(
  parameter int DIVISOR = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  // At least one bit so DIVISOR=1 still yields a legal counter.
  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] count;

  // A clear on the wrap cycle suppresses the pulse so the restarted phase
  // never sees a stale tick.
  assign tick = !clear && (count == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : uart_rx                                                      |
// | Purpose   : UART receiver. Recovers start / 8 data (LSB first) /         |
// |             optional parity / 1 stop frames using an oversampled tick,   |
// |             presents the byte with a one-cycle done pulse.               |
// | Ports     : clock, reset (async, active-high)                            |
// |             rx_in      - serial line, idle high, asynchronous            |
// |             parity_odd - 1 = odd parity, 0 = even                        |
// |             rx_data    - last received byte                              |
// |             rx_done    - one-cycle frame-complete pulse                  |
// |             rx_busy    - high whenever the FSM is not idle               |
// |             parity_err - parity mismatch of the last frame               |
// |             frame_err  - stop bit sampled low on the last frame          |
// | Config    : define UART_RX_PARITY_EN for 8E1/8O1; default build is 8N1   |
// |             with parity_err tied low.                                    |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module uart_rx
  import uart_pkg::*;
#(
  parameter int DIVISOR    = 4,
  parameter int OVERSAMPLE = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_in,
  input  logic              parity_odd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_done,
  output logic              rx_busy,
  output logic              parity_err,
  output logic              frame_err
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);

  uart_state_t       state, state_n;
  logic              sync1, rx_s, rx_prev;
  logic              tick;
  logic [SW-1:0]     samp_cnt;
  logic [2:0]        bit_cnt;
  logic [DATA_W-1:0] shift_reg;

  logic start_det, sample, shift_en, par_en, finish;

  uart_baud_tick #(.DIVISOR(DIVISOR)) u_baud_tick (
    .clock (clock),
    .reset (reset),
    .clear (start_det),
    .tick  (tick)
  );

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx_in;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    start_det = 1'b0;
    sample    = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        // Edge (not level) detection: a line stuck low after a bad stop
        // bit must go high again before a new frame is accepted.
        if (rx_prev && !rx_s) begin
          start_det = 1'b1;
          state_n   = START;
        end
      end
      START: begin
        if (tick && samp_cnt == HALF_LAST) begin
          sample  = 1'b1;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick && samp_cnt == FULL_LAST) begin
          sample   = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick && samp_cnt == FULL_LAST) begin
          sample  = 1'b1;
          par_en  = 1'b1;
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (tick && samp_cnt == FULL_LAST) begin
          sample  = 1'b1;
          finish  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign rx_busy = (state != IDLE);

  // Sample counter restarts at each sample point, so OVERSAMPLE need not be
  // a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      samp_cnt  <= '0;
      bit_cnt   <= 3'd0;
      shift_reg <= '0;
    end else begin
      if (start_det || sample) samp_cnt <= '0;
      else if (tick)           samp_cnt <= samp_cnt + SW'(1);

      if (start_det)     bit_cnt <= 3'd0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;

      if (shift_en) shift_reg <= {rx_s, shift_reg[DATA_W-1:1]};
    end
  end

  // Outputs are registered on the stop-sample edge, so rx_done is high in
  // the cycle right after the mid-stop sample tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done <= finish;
      if (finish) begin
        rx_data   <= shift_reg;
        frame_err <= ~rx_s;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_bad;

  // parity_odd is taken at the parity sample tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      parity_bad <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (start_det)   parity_bad <= 1'b0;
      else if (par_en) parity_bad <= rx_s ^ (^shift_reg) ^ parity_odd;
      if (finish) parity_err <= parity_bad;
    end
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd ^ par_en;
  assign parity_err        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_uart_rx                                                   |
// | Purpose   : Directed self-checking bench for uart_rx at DIVISOR=4,       |
// |             OVERSAMPLE=16 (64-clock bits). Parity cases run only when    |
// |             UART_RX_PARITY_EN is defined.                                |
// | Revision  : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module tb_uart_rx;

  localparam int BIT = 64;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Line fall to rx_done: 2 sync + 1 detect + 4 clocks/tick * 152 ticks.
  localparam int LATENCY = 611 + (NBITS - 10) * BIT;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx_in = 1'b1;
  logic       parity_odd = 1'b0;
  logic [7:0] rx_data;
  logic       rx_done, rx_busy, parity_err, frame_err;

  uart_rx #(.DIVISOR(4), .OVERSAMPLE(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_in      (rx_in),
    .parity_odd (parity_odd),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .rx_busy    (rx_busy),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_t = 0, prev_t = 0;
  int start_cyc = 0;
  int long_pulse = 0;
  logic [7:0] last_d = 8'h00, prev_d = 8'h00;
  logic prev_done = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (rx_done) begin
      prev_t   = last_t;
      last_t   = cyc;
      prev_d   = last_d;
      last_d   = rx_data;
      done_cnt = done_cnt + 1;
    end
    if (rx_done && prev_done) long_pulse = long_pulse + 1;
    prev_done = rx_done;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests = tests + 1;
    if (got !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx_in = v;
    repeat (BIT) @(negedge clock);
  endtask

  // Called at a negedge; leaves rx_in at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`else
    if (par) rx_in = rx_in;
`endif
    drive_bit(stop);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clock);
    check("reset_data", {24'd0, rx_data}, 32'h00);
    check("reset_done", {31'd0, rx_done}, 32'h0);
    check("reset_busy", {31'd0, rx_busy}, 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check("idle_perr", {31'd0, parity_err}, 32'h0);
    check("idle_ferr", {31'd0, frame_err}, 32'h0);

    // Clean frame 0xA5 (even weight, parity bit 0)
    n = done_cnt;
    send_frame(8'hA5, 1'b1, 1'b0);
    repeat (20) @(negedge clock);
    check("a5_count", done_cnt - n, 1);
    check("a5_data", {24'd0, last_d}, 32'hA5);
    check("a5_ferr", {31'd0, frame_err}, 32'h0);
    check("a5_perr", {31'd0, parity_err}, 32'h0);
    check("a5_latency", last_t - start_cyc, LATENCY);

    // Glitch shorter than half a bit
    n = done_cnt;
    rx_in = 1'b0;
    repeat (10) @(negedge clock);
    rx_in = 1'b1;
    repeat (50) @(negedge clock);
    check("glitch_busy", {31'd0, rx_busy}, 32'h0);
    check("glitch_count", done_cnt - n, 0);
    check("glitch_data", {24'd0, rx_data}, 32'hA5);

    // Framing error, line then held low
    n = done_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (20) @(negedge clock);
    check("ferr_count", done_cnt - n, 1);
    check("ferr_data", {24'd0, last_d}, 32'h3C);
    check("ferr_flag", {31'd0, frame_err}, 32'h1);
    repeat (300) @(negedge clock);
    check("ferr_held_busy", {31'd0, rx_busy}, 32'h0);
    check("ferr_held_count", done_cnt - n, 1);
    rx_in = 1'b1;
    repeat (BIT) @(negedge clock);

    // Back-to-back frames
    n = done_cnt;
    send_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'hAA, 1'b1, 1'b0);
    repeat (20) @(negedge clock);
    check("b2b_count", done_cnt - n, 2);
    check("b2b_first", {24'd0, prev_d}, 32'h55);
    check("b2b_second", {24'd0, last_d}, 32'hAA);
    check("b2b_spacing", last_t - prev_t, NBITS * BIT);
    check("b2b_ferr", {31'd0, frame_err}, 32'h0);

    // Reset during data bit 4 of 0xFF
    n = done_cnt;
    rx_in = 1'b0;
    repeat (BIT) @(negedge clock);
    rx_in = 1'b1;
    repeat (4 * BIT + BIT / 2) @(negedge clock);
    check("pre_reset_busy", {31'd0, rx_busy}, 32'h1);
    reset = 1'b1;
    #1;
    check("rst_data", {24'd0, rx_data}, 32'h00);
    check("rst_busy", {31'd0, rx_busy}, 32'h0);
    check("rst_done", {31'd0, rx_done}, 32'h0);
    check("rst_ferr", {31'd0, frame_err}, 32'h0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (8 * BIT) @(negedge clock);
    check("rst_no_done", done_cnt - n, 0);
    send_frame(8'h81, 1'b1, 1'b0);
    repeat (20) @(negedge clock);
    check("after_rst_count", done_cnt - n, 1);
    check("after_rst_data", {24'd0, rx_data}, 32'h81);

`ifdef UART_RX_PARITY_EN
    // 0x0F has four ones: even parity bit is 0, odd parity bit is 1
    parity_odd = 1'b0;
    send_frame(8'h0F, 1'b1, 1'b0);
    repeat (20) @(negedge clock);
    check("par_even_ok", {31'd0, parity_err}, 32'h0);
    check("par_even_ok_data", {24'd0, rx_data}, 32'h0F);
    send_frame(8'h0F, 1'b1, 1'b1);
    repeat (20) @(negedge clock);
    check("par_even_bad", {31'd0, parity_err}, 32'h1);
    parity_odd = 1'b1;
    send_frame(8'h0F, 1'b1, 1'b1);
    repeat (20) @(negedge clock);
    check("par_odd_ok", {31'd0, parity_err}, 32'h0);
    check("par_ferr", {31'd0, frame_err}, 32'h0);
`endif

    check("done_pulse_width", long_pulse, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

UART receiver: the receive-side counterpart of the UART transmit path. Recovers asynchronous serial frames (start, 8 data bits LSB first, optional parity, one stop bit) from the line using an oversampled baud tick. Presents the byte on a parallel register with a one-cycle done flag. Sits between the pad/line input and the consumer logic that reads received bytes.

## Interface
- `DIVISOR`, default 4: clock cycles per oversample tick (≥1).
- `OVERSAMPLE`, default 16: oversample ticks per bit period (even, ≥4).
- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `rx_in` in 1: serial line, idle high, asynchronous to `clock`.
- `parity_odd` in 1: 1 selects odd parity, 0 selects even. Ignored without `UART_RX_PARITY_EN`.
- `rx_data` out 8: last received byte; holds until the next completed frame.
- `rx_done` out 1: one-cycle pulse when a frame completes; `rx_data` and the error flags are valid in that cycle.
- `rx_busy` out 1: high in every state except IDLE.
- `parity_err` out 1: parity mismatch on the last frame; updated with `rx_done`.
- `frame_err` out 1: stop bit sampled low on the last frame; updated with `rx_done`.

## Operation
- `rx_in` passes through a 2-flop synchronizer; all logic uses the synchronized value `rx_s`.
- Tick generator: counter 0..DIVISOR-1; `tick` pulses on wrap. Counter is cleared on start detection so sampling is phase-aligned to the falling edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on `rx_s` high→low, clear the tick and sample counters and go to START.
  - START: after OVERSAMPLE/2 ticks (mid start bit), sample. If `rx_s`=1 it is a false start: go to IDLE with no `rx_done`. Otherwise go to DATA.
  - DATA: every OVERSAMPLE ticks, shift `rx_s` into the shift register, LSB first. After bit 7, go to PARITY (macro defined) or STOP.
  - PARITY: after OVERSAMPLE ticks, sample the parity bit. Expected bit = XOR of data bits, inverted when `parity_odd`=1. Latch the mismatch and go to STOP.
  - STOP: after OVERSAMPLE ticks, sample. `frame_err` = ~`rx_s`. In the following cycle, load `rx_data`, `parity_err` and `frame_err`, pulse `rx_done`, and go to IDLE.
- A frame with a framing error still delivers its byte.
- Return to IDLE requires `rx_s`=1 before a new start is accepted. If the line is held low after a bad stop bit, no new frame is detected until it goes high.
- Sample counter width is clog2(OVERSAMPLE). Bit counter is 3 bits; it wraps after 8 bits and is not reused.

## Timing
- Reset values: `rx_data`=8'h00, `rx_done`=0, `rx_busy`=0, `parity_err`=0, `frame_err`=0. FSM goes to IDLE and the synchronizer to 1.
- Bit period = DIVISOR×OVERSAMPLE clocks (64 at defaults).
- Input latency: 2 clocks (synchronizer).
- Sample point: mid-bit, at OVERSAMPLE/2 ticks after the detected edge plus k×OVERSAMPLE ticks.
- `rx_done` asserts exactly 1 clock after the mid-stop-bit sample tick, and is high for exactly 1 clock.
- Back-to-back frames: a start edge arriving 0.5 bit after the stop sample is accepted; no idle gap is required beyond the stop bit.
- Reset asserted mid-frame: immediate return to IDLE, no `rx_done`, and all outputs take their reset values.
- Changing `parity_odd` mid-frame: the value is taken at the parity sample tick.

## Configuration
- `UART_RX_PARITY_EN` defined: frame is 8E1 or 8O1; the PARITY state exists; `parity_err` is driven as specified.
- `UART_RX_PARITY_EN` not defined: frame is 8N1; the PARITY state is removed (DATA goes to STOP); `parity_err` is tied 0; `parity_odd` is unused.

## Structure
- Shared package/header `uart_pkg`: FSM state encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4) and the frame data width constant (8). Both uart_rx and the transmit path use it.
- One sub-module, `uart_baud_tick`: the DIVISOR counter with a synchronous clear input and a `tick` output. It is reusable by the transmitter.

## Test plan
All cases use defaults: DIVISOR=4, OVERSAMPLE=16, 64-clock bits.
- 8N1 (macro off): send 0xA5 with a valid stop bit → one `rx_done` pulse, `rx_data`=0xA5, `frame_err`=0, `parity_err`=0.
- Glitch: `rx_in` low for 10 clocks, then high → no `rx_done`; `rx_busy` returns to 0 by mid-start; `rx_data` unchanged.
- Framing error: send 0x3C with stop bit driven 0 → `rx_done` pulse, `rx_data`=0x3C, `frame_err`=1. No new frame until the line returns high.
- Parity (macro on, `parity_odd`=0): 0x0F with parity bit 0 → `parity_err`=0. Same byte with parity bit 1 → `parity_err`=1. With `parity_odd`=1 and parity bit 1 → `parity_err`=0.
- Back-to-back: 0x55 then 0xAA with no idle gap → two `rx_done` pulses exactly 10 bit periods apart (11 with parity), carrying 0x55 then 0xAA.
- Reset mid-frame: assert `reset` during data bit 4 of 0xFF → all outputs 0 and no `rx_done`. A following frame 0x81 is received correctly.
